// File: rtl/reg_file_2r1w_pkg.sv
// Shared constants and elaboration helpers for the two-read, one-write register file.
package reg_file_2r1w_pkg;

   localparam int unsigned BYTE_W        = 8;
   localparam int unsigned DEFAULT_WIDTH = 32;
   localparam int unsigned DEFAULT_DEPTH = 8;

   // Byte-lane count for a given data width.
   function automatic int unsigned lanes_f(input int unsigned width);
      return width / BYTE_W;
   endfunction

   // Address width; a depth of 1 would give a zero-width bus, so floor at one bit.
   function automatic int unsigned addr_w_f(input int unsigned depth);
      return (depth < 2) ? 32'd1 : 32'($clog2(depth));
   endfunction

   function automatic bit width_ok_f(input int unsigned width);
      return (width != 0) && ((width % BYTE_W) == 0);
   endfunction

   function automatic bit depth_ok_f(input int unsigned depth);
      return depth >= 2;
   endfunction

endpackage

// File: rtl/reg_file_2r1w_rf_word.sv
// One register-file word: WIDTH bits with a write strobe and per-byte write enables.
module reg_file_2r1w_rf_word
   import reg_file_2r1w_pkg::*;
#(
   parameter  int unsigned WIDTH = DEFAULT_WIDTH,
   localparam int unsigned LANES = lanes_f(WIDTH)
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Wr_Stb,
   input  logic [LANES-1:0] Byte_En,
   input  logic [WIDTH-1:0] Wr_Data,
   output logic [WIDTH-1:0] Word
);

   logic [WIDTH-1:0] word_q;

   // Only enabled lanes are updated; the rest hold their value.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         word_q <= '0;
      end else if (Wr_Stb) begin
         for (int i = 0; i < int'(LANES); i++) begin
            if (Byte_En[i]) begin
               word_q[i*BYTE_W +: BYTE_W] <= Wr_Data[i*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   assign Word = word_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// Parametrised register file: one byte-masked write port, two combinational read ports
// with optional hardwired-zero word 0 and optional write-to-read bypass.
module reg_file_2r1w
   import reg_file_2r1w_pkg::*;
#(
   parameter  int unsigned WIDTH    = DEFAULT_WIDTH,
   parameter  int unsigned DEPTH    = DEFAULT_DEPTH,
   parameter  bit          ZERO_REG = 1'b1,
   parameter  bit          BYPASS   = 1'b1,
   localparam int unsigned ADDR_W   = addr_w_f(DEPTH),
   localparam int unsigned LANES    = lanes_f(WIDTH)
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              We,
   input  logic [ADDR_W-1:0] Wr_Addr,
   input  logic [WIDTH-1:0]  Wr_Data,
   input  logic [LANES-1:0]  Byte_En,
   input  logic [ADDR_W-1:0] Rd_Addr_A,
   output logic [WIDTH-1:0]  Rd_Data_A,
   input  logic [ADDR_W-1:0] Rd_Addr_B,
   output logic [WIDTH-1:0]  Rd_Data_B
);

   if (!width_ok_f(WIDTH)) begin : g_bad_width
      $error("reg_file_2r1w: WIDTH must be a non-zero multiple of 8");
   end
   if (!depth_ok_f(DEPTH)) begin : g_bad_depth
      $error("reg_file_2r1w: DEPTH must be at least 2");
   end

   logic [WIDTH-1:0] word_q [DEPTH];
   logic [WIDTH-1:0] stored_a_c;
   logic [WIDTH-1:0] stored_b_c;
   logic             wr_valid_c;
   logic             hit_a_c;
   logic             hit_b_c;

   // Storage bank; word 0 is a constant when it is the hardwired-zero register.
   for (genvar g = 0; g < int'(DEPTH); g++) begin : g_word
      if (ZERO_REG && (g == 0)) begin : g_zero
         assign word_q[g] = '0;
      end else begin : g_reg
         logic wr_stb;
         assign wr_stb = We && (Wr_Addr == ADDR_W'(g));
         reg_file_2r1w_rf_word #(
            .WIDTH (WIDTH)
         ) u_word (
            .Clock   (Clock),
            .Reset   (Reset),
            .Wr_Stb  (wr_stb),
            .Byte_En (Byte_En),
            .Wr_Data (Wr_Data),
            .Word    (word_q[g])
         );
      end
   end

   function automatic logic [WIDTH-1:0] merge_bytes(
      input logic [WIDTH-1:0] new_data,
      input logic [WIDTH-1:0] old_data,
      input logic [LANES-1:0] mask
   );
      logic [WIDTH-1:0] r;
      r = old_data;
      for (int i = 0; i < int'(LANES); i++) begin
         if (mask[i]) begin
            r[i*BYTE_W +: BYTE_W] = new_data[i*BYTE_W +: BYTE_W];
         end
      end
      return r;
   endfunction

   // Read muxes: addresses with no matching word (out of range) fall through to zero.
   always_comb begin
      stored_a_c = '0;
      stored_b_c = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (Rd_Addr_A == ADDR_W'(i)) begin
            stored_a_c = word_q[i];
         end
         if (Rd_Addr_B == ADDR_W'(i)) begin
            stored_b_c = word_q[i];
         end
      end
   end

   // A write only lands (and so only bypasses) on an in-range, writable word.
   always_comb begin
      wr_valid_c = (32'(Wr_Addr) < DEPTH) && !(ZERO_REG && (Wr_Addr == '0));
      hit_a_c    = BYPASS && We && wr_valid_c && (Rd_Addr_A == Wr_Addr);
      hit_b_c    = BYPASS && We && wr_valid_c && (Rd_Addr_B == Wr_Addr);
   end

   always_comb begin
      Rd_Data_A = hit_a_c ? merge_bytes(Wr_Data, stored_a_c, Byte_En) : stored_a_c;
      Rd_Data_B = hit_b_c ? merge_bytes(Wr_Data, stored_b_c, Byte_En) : stored_b_c;
   end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench: dut1 is DEPTH=8/ZERO_REG=1/BYPASS=1, dut2 is DEPTH=6/ZERO_REG=0/BYPASS=0.
module tb_reg_file_2r1w;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        we1, we2;
   logic [2:0]  wa1, wa2, ra1, rb1, ra2, rb2;
   logic [31:0] wd1, wd2;
   logic [3:0]  be1, be2;
   logic [31:0] qa1, qb1, qa2, qb2;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          q_sel  [$];
   logic [31:0] q_exp  [$];
   string       q_name [$];
   event        sample_ev;
   logic [31:0] exp2 [6];

   always #5 Clock = ~Clock;

   reg_file_2r1w #(.WIDTH(32), .DEPTH(8), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut1 (
      .Clock(Clock), .Reset(Reset), .We(we1), .Wr_Addr(wa1), .Wr_Data(wd1), .Byte_En(be1),
      .Rd_Addr_A(ra1), .Rd_Data_A(qa1), .Rd_Addr_B(rb1), .Rd_Data_B(qb1));

   reg_file_2r1w #(.WIDTH(32), .DEPTH(6), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut2 (
      .Clock(Clock), .Reset(Reset), .We(we2), .Wr_Addr(wa2), .Wr_Data(wd2), .Byte_En(be2),
      .Rd_Addr_A(ra2), .Rd_Data_A(qa2), .Rd_Addr_B(rb2), .Rd_Data_B(qb2));

   // sel: 0 = dut1 port A, 1 = dut1 port B, 2 = dut2 port A, 3 = dut2 port B
   task automatic expect_rd(input int sel, input string nm, input logic [31:0] exp);
      q_sel.push_back(sel);
      q_exp.push_back(exp);
      q_name.push_back(nm);
   endtask

   task automatic sample();
      -> sample_ev;
      #2;
   endtask

   task automatic idle();
      we1 = 1'b0; we2 = 1'b0; be1 = 4'h0; be2 = 4'h0;
      wa1 = 3'd0; wa2 = 3'd0; wd1 = 32'h0; wd2 = 32'h0;
   endtask

   task automatic wr_both(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge Clock);
      we1 = 1'b1; wa1 = a; wd1 = d; be1 = be;
      we2 = 1'b1; wa2 = a; wd2 = d; be2 = be;
      ra1 = 3'd7; rb1 = 3'd7; ra2 = 3'd1; rb2 = 3'd1;
      @(posedge Clock);
      @(negedge Clock);
      idle();
   endtask

   task automatic set_rd(input logic [2:0] a1, input logic [2:0] b1,
                         input logic [2:0] a2, input logic [2:0] b2);
      ra1 = a1; rb1 = b1; ra2 = a2; rb2 = b2;
   endtask

   // Monitor: each sample strobe, drain the queued expectations against the read ports.
   initial begin
      int          sel;
      logic [31:0] exp;
      logic [31:0] act;
      string       nm;
      forever begin
         @(sample_ev);
         #1;
         while (q_exp.size() > 0) begin
            sel = q_sel.pop_front();
            exp = q_exp.pop_front();
            nm  = q_name.pop_front();
            case (sel)
               0:       act = qa1;
               1:       act = qb1;
               2:       act = qa2;
               default: act = qb2;
            endcase
            n_cmp++;
            if (act !== exp) begin
               n_bad++;
               $display("FAIL %s: got %08h expected %08h", nm, act, exp);
            end
         end
      end
   end

   initial begin
      #100000;
      n_bad++;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      idle();
      set_rd(3'd0, 3'd0, 3'd0, 3'd0);
      Reset = 1'b0;
      #12;
      @(negedge Clock);
      Reset = 1'b1;

      // Every address reads zero after reset, including dut2's out-of-range 6 and 7.
      for (int i = 0; i < 8; i++) begin
         set_rd(3'(i), 3'(7 - i), 3'(i), 3'(7 - i));
         expect_rd(0, $sformatf("reset d1.A[%0d]", i), 32'h0);
         expect_rd(1, $sformatf("reset d1.B[%0d]", 7 - i), 32'h0);
         expect_rd(2, $sformatf("reset d2.A[%0d]", i), 32'h0);
         expect_rd(3, $sformatf("reset d2.B[%0d]", 7 - i), 32'h0);
         sample();
      end

      wr_both(3'd3, 32'hDEADBEEF, 4'b1111);
      set_rd(3'd3, 3'd3, 3'd3, 3'd3);
      expect_rd(0, "full write d1.A", 32'hDEADBEEF);
      expect_rd(1, "full write d1.B", 32'hDEADBEEF);
      expect_rd(2, "full write d2.A", 32'hDEADBEEF);
      sample();

      wr_both(3'd3, 32'h11223344, 4'b0101);
      set_rd(3'd3, 3'd3, 3'd3, 3'd3);
      expect_rd(0, "byte merge d1", 32'hDE22BE44);
      expect_rd(3, "byte merge d2", 32'hDE22BE44);
      sample();

      wr_both(3'd3, 32'hFFFFFFFF, 4'b0000);
      set_rd(3'd3, 3'd3, 3'd3, 3'd3);
      expect_rd(0, "be=0 noop d1", 32'hDE22BE44);
      expect_rd(2, "be=0 noop d2", 32'hDE22BE44);
      sample();

      wr_both(3'd0, 32'hFFFFFFFF, 4'b1111);
      set_rd(3'd0, 3'd0, 3'd0, 3'd0);
      expect_rd(0, "zero reg d1", 32'h0);
      expect_rd(2, "normal reg0 d2", 32'hFFFFFFFF);
      sample();

      // Bypass never exposes data for the hardwired-zero word.
      @(negedge Clock);
      we1 = 1'b1; wa1 = 3'd0; wd1 = 32'h12345678; be1 = 4'b1111;
      set_rd(3'd0, 3'd0, 3'd0, 3'd0);
      expect_rd(0, "zero reg bypass d1.A", 32'h0);
      expect_rd(1, "zero reg bypass d1.B", 32'h0);
      sample();
      @(posedge Clock);
      @(negedge Clock);
      idle();

      wr_both(3'd5, 32'hAAAAAAAA, 4'b1111);
      @(negedge Clock);
      we1 = 1'b1; wa1 = 3'd5; wd1 = 32'h55555555; be1 = 4'b0011;
      we2 = 1'b1; wa2 = 3'd5; wd2 = 32'h55555555; be2 = 4'b0011;
      set_rd(3'd5, 3'd5, 3'd5, 3'd5);
      expect_rd(0, "bypass pre-edge d1.A", 32'hAAAA5555);
      expect_rd(1, "bypass pre-edge d1.B", 32'hAAAA5555);
      expect_rd(2, "no bypass pre-edge d2.A", 32'hAAAAAAAA);
      expect_rd(3, "no bypass pre-edge d2.B", 32'hAAAAAAAA);
      sample();
      @(posedge Clock);
      @(negedge Clock);
      idle();
      expect_rd(0, "post-edge d1.A", 32'hAAAA5555);
      expect_rd(1, "post-edge d1.B", 32'hAAAA5555);
      expect_rd(2, "post-edge d2.A", 32'hAAAA5555);
      expect_rd(3, "post-edge d2.B", 32'hAAAA5555);
      sample();

      // Ports bypass independently: A reads another word while B hits the write.
      @(negedge Clock);
      we1 = 1'b1; wa1 = 3'd4; wd1 = 32'h01020304; be1 = 4'b1000;
      set_rd(3'd3, 3'd4, 3'd0, 3'd0);
      expect_rd(0, "independent A d1", 32'hDE22BE44);
      expect_rd(1, "independent B bypass d1", 32'h01000000);
      sample();
      @(posedge Clock);
      @(negedge Clock);
      idle();
      expect_rd(1, "independent B stored d1", 32'h01000000);
      sample();

      // Out-of-range write on the six-word instance.
      @(negedge Clock);
      we2 = 1'b1; wa2 = 3'd6; wd2 = 32'h12345678; be2 = 4'b1111;
      set_rd(3'd0, 3'd0, 3'd6, 3'd6);
      expect_rd(3, "oor read pre-edge d2", 32'h0);
      sample();
      @(posedge Clock);
      @(negedge Clock);
      idle();
      set_rd(3'd0, 3'd0, 3'd7, 3'd6);
      expect_rd(2, "oor read addr7 d2", 32'h0);
      expect_rd(3, "oor read addr6 d2", 32'h0);
      sample();
      exp2[0] = 32'hFFFFFFFF; exp2[1] = 32'h0;        exp2[2] = 32'h0;
      exp2[3] = 32'hDE22BE44; exp2[4] = 32'h0;        exp2[5] = 32'hAAAA5555;
      for (int i = 0; i < 6; i++) begin
         set_rd(3'd0, 3'd0, 3'(i), 3'(i));
         expect_rd(2, $sformatf("oor unchanged d2[%0d]", i), exp2[i]);
         sample();
      end

      // Asynchronous reset between edges clears stored data before the next edge.
      wr_both(3'd2, 32'hCAFEF00D, 4'b1111);
      set_rd(3'd2, 3'd2, 3'd2, 3'd2);
      expect_rd(0, "pre-reset d1", 32'hCAFEF00D);
      expect_rd(2, "pre-reset d2", 32'hCAFEF00D);
      sample();
      @(negedge Clock);
      #1;
      Reset = 1'b0;
      expect_rd(0, "async reset d1", 32'h0);
      expect_rd(3, "async reset d2", 32'h0);
      sample();
      @(negedge Clock);
      we1 = 1'b1; wa1 = 3'd2; wd1 = 32'hFFFFFFFF; be1 = 4'b1111;
      we2 = 1'b1; wa2 = 3'd2; wd2 = 32'hFFFFFFFF; be2 = 4'b1111;
      @(posedge Clock);
      @(negedge Clock);
      idle();
      expect_rd(1, "write in reset d1", 32'h0);
      expect_rd(2, "write in reset d2", 32'h0);
      sample();
      @(negedge Clock);
      Reset = 1'b1;
      set_rd(3'd2, 3'd5, 3'd2, 3'd3);
      expect_rd(0, "after reset d1[2]", 32'h0);
      expect_rd(1, "after reset d1[5]", 32'h0);
      expect_rd(2, "after reset d2[2]", 32'h0);
      expect_rd(3, "after reset d2[3]", 32'h0);
      sample();

      wr_both(3'd2, 32'h0BADF00D, 4'b1111);
      set_rd(3'd2, 3'd2, 3'd2, 3'd2);
      expect_rd(1, "write after reset d1", 32'h0BADF00D);
      expect_rd(3, "write after reset d2", 32'h0BADF00D);
      sample();

      #5;
      if (q_exp.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending checks expected 0", q_exp.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised register file: DEPTH words of WIDTH bits, one write port, two read ports.
- Generalises the single enabled 32-bit register into an addressable bank.
- Adds per-byte write enables, an optional hardwired-zero word 0 and optional write-to-read bypass.
- Sits between the datapath ALU and the operand-fetch stage of the CPU exercises.

Parameters:
WIDTH, 32, data word width in bits; must be a multiple of 8
DEPTH, 8, number of words; need not be a power of two, must be >= 2
ZERO_REG, 1, 1 = word 0 always reads 0 and ignores writes; 0 = word 0 is a normal register
BYPASS, 1, 1 = a read of the address being written this cycle returns the merged new data; 0 = returns stored contents
ADDR_W, $clog2(DEPTH), address width; derived, not overridden

Ports:
Clock  input  1  single system clock, rising-edge active
Reset  input  1  asynchronous, active-low reset; clears every word to 0
We  input  1  write enable, sampled at rising Clock
Wr_Addr  input  ADDR_W  write address
Wr_Data  input  WIDTH  write data
Byte_En  input  WIDTH/8  per-byte write mask; bit i covers bits [8i+7:8i]
Rd_Addr_A  input  ADDR_W  read port A address
Rd_Data_A  output  WIDTH  read port A data, combinational
Rd_Addr_B  input  ADDR_W  read port B address
Rd_Data_B  output  WIDTH  read port B data, combinational

Behaviour:
- Reset low, at any time including mid-write:
  - All words become 0 immediately.
  - No write occurs while Reset is low.
  - Rd_Data_A and Rd_Data_B read 0 after reset settles.
- Write, at the rising Clock edge with Reset high and We=1:
  - For each byte i with Byte_En[i]=1, word[Wr_Addr] byte i <= Wr_Data byte i.
  - Bytes with Byte_En[i]=0 keep their value.
  - Latency: new data is visible in storage one edge after the write is presented.
- No-op cases:
  - We=1 with Byte_En all zero is a no-op.
  - We=0: storage holds.
- Out-of-range addresses (address >= DEPTH, possible when DEPTH is not a power of two):
  - Writes are ignored.
  - Reads return 0.
- ZERO_REG=1:
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0 regardless of BYPASS.
- Reads:
  - Purely combinational from storage plus bypass mux.
  - No read enable, no state change on read.
- BYPASS=1:
  - When We=1 and Rd_Addr_X == Wr_Addr (valid, non-zero-reg), Rd_Data_X = per-byte merge of Wr_Data (enabled bytes) and stored word (disabled bytes).
  - Both ports bypass independently.
  - Both ports may read the same address.
- BYPASS=0: reads always return the stored value; the new value appears after the edge.
- Simultaneous events: read and write of the same address in one cycle follow the BYPASS rule; two reads of one address are always legal.
- No X propagation: all storage is reset, and every read path has a defined value for every address.

Decomposition:
- Shared package/header holds:
  - Byte-lane count constant, WIDTH/8.
  - Elaboration-time checks: WIDTH%8==0, DEPTH>=2.
  - ADDR_W derivation function.
- Natural sub-module: rf_word.
  - One WIDTH-bit register with async active-low Reset, a write strobe and a per-byte enable.
  - The direct successor of the single enabled register.
  - Generated DEPTH times; word 0 omitted when ZERO_REG=1.
- Read muxes and bypass logic stay in the top module.

Test Plan:
- Reset low, then high; read all addresses on both ports -> every Rd_Data = 0x00000000.
- Write 0xDEADBEEF to addr 3 with Byte_En=4'b1111; next cycle Rd_Addr_A=3 -> 0xDEADBEEF.
- Then write 0x11223344 to addr 3 with Byte_En=4'b0101 -> 0xDE22BE44.
- ZERO_REG=1: write 0xFFFFFFFF to addr 0 -> Rd_Data_A(addr 0)=0. ZERO_REG=0: same write -> 0xFFFFFFFF.
- BYPASS=1, addr 5 holds 0xAAAAAAAA; same cycle We=1, Wr_Addr=5, Wr_Data=0x55555555, Byte_En=4'b0011, Rd_Addr_A=Rd_Addr_B=5 -> both read 0xAAAA5555 before the edge. BYPASS=0 -> both read 0xAAAAAAAA before the edge and 0xAAAA5555 after it.
- DEPTH=6: write 0x12345678 to addr 6 -> no word changes; Rd_Addr_B=6 -> 0; addr 0..5 contents unchanged.
- Write 0xCAFEF00D to addr 2, then assert Reset low mid-cycle asynchronously (between edges) -> Rd_Data(addr 2)=0 before the next Clock edge; write attempts while Reset is low have no effect.
